// File: rtl/timer_periph_if.sv
// CPU data-bus view of the interval timer: load/store strobes, address/data, decode hit and IRQ.
interface timer_periph_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        hit;
  logic        irq;

  modport master (
    output mem_read, mem_write, address, write_data,
    input  read_data, hit, irq
  );

  modport slave (
    input  mem_read, mem_write, address, write_data,
    output read_data, hit, irq
  );
endinterface

// File: rtl/timer_periph.sv
// Memory-mapped interval timer (TH/TL/TCON/SYSTICK) with level IRQ on the CPU data bus.
// Optional prescaler compiled in with macro TIMER_PRESCALER_EN.
module timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 100
) (
  input  logic          clk,
  input  logic          reset,
  timer_periph_if.slave bus
);
  localparam logic [31:0] ADDR_TH      = BASE_ADDR;
  localparam logic [31:0] ADDR_TL      = BASE_ADDR + 32'h0000_0004;
  localparam logic [31:0] ADDR_TCON    = BASE_ADDR + 32'h0000_0008;
  localparam logic [31:0] ADDR_SYSTICK = BASE_ADDR + 32'h0000_000C;
  localparam logic [31:0] TL_MAX       = 32'hFFFF_FFFF;

  if ((PRESCALE < 32'd1) || (PRESCALE > 32'd65535)) begin : g_prescale_range
    $error("timer_periph: PRESCALE must be in 1..65535");
  end

  logic [31:0] th_r;
  logic [31:0] tl_r;
  logic [31:0] systick_r;
  logic        en_r;
  logic        ie_r;
  logic        st_r;

  logic        sel_th_s;
  logic        sel_tl_s;
  logic        sel_tcon_s;
  logic        sel_systick_s;
  logic        hit_s;
  logic [31:0] reg_data_s;
  logic [31:0] read_data_s;
  logic        wr_th_s;
  logic        wr_tl_s;
  logic        wr_tcon_s;
  logic        tick_s;
  logic        count_s;
  logic        ovf_s;

  // Exact-address decode and zero-latency read mux
  always_comb begin
    sel_th_s      = 1'b0;
    sel_tl_s      = 1'b0;
    sel_tcon_s    = 1'b0;
    sel_systick_s = 1'b0;
    reg_data_s    = 32'h0000_0000;
    case (bus.address)
      ADDR_TH:      begin sel_th_s      = 1'b1; reg_data_s = th_r; end
      ADDR_TL:      begin sel_tl_s      = 1'b1; reg_data_s = tl_r; end
      ADDR_TCON:    begin sel_tcon_s    = 1'b1; reg_data_s = {29'h0, st_r, ie_r, en_r}; end
      ADDR_SYSTICK: begin sel_systick_s = 1'b1; reg_data_s = systick_r; end
      default:      begin reg_data_s    = 32'h0000_0000; end
    endcase
    hit_s = sel_th_s | sel_tl_s | sel_tcon_s | sel_systick_s;
    if (bus.mem_read && hit_s) begin
      read_data_s = reg_data_s;
    end else begin
      read_data_s = 32'h0000_0000;
    end
  end

  assign wr_th_s   = bus.mem_write & sel_th_s;
  assign wr_tl_s   = bus.mem_write & sel_tl_s;
  assign wr_tcon_s = bus.mem_write & sel_tcon_s;

`ifdef TIMER_PRESCALER_EN
  localparam logic [15:0] PC_LAST = 16'(PRESCALE - 32'd1);
  logic [15:0] pc_r;

  // Prescale counter: runs while enabled, restarts on any TCON write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= 16'h0000;
    end else if (wr_tcon_s) begin
      pc_r <= 16'h0000;
    end else if (en_r) begin
      pc_r <= (pc_r == PC_LAST) ? 16'h0000 : pc_r + 16'h0001;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign tick_s = (pc_r == PC_LAST);
`else
  assign tick_s = 1'b1;
`endif

  assign count_s = en_r & tick_s;
  assign ovf_s   = count_s & (tl_r == TL_MAX);

  // Reload register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_r <= 32'h0000_0000;
    end else if (wr_th_s) begin
      th_r <= bus.write_data;
    end else begin
      th_r <= th_r;
    end
  end

  // Counter: a bus write beats the overflow reload, which uses the pre-edge TH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tl_r <= 32'h0000_0000;
    end else if (wr_tl_s) begin
      tl_r <= bus.write_data;
    end else if (ovf_s) begin
      tl_r <= th_r;
    end else if (count_s) begin
      tl_r <= tl_r + 32'h0000_0001;
    end else begin
      tl_r <= tl_r;
    end
  end

  // Control/status: an overflow set wins over a software clear so no interrupt is lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_r <= 1'b0;
      ie_r <= 1'b0;
      st_r <= 1'b0;
    end else begin
      if (wr_tcon_s) begin
        en_r <= bus.write_data[0];
        ie_r <= bus.write_data[1];
      end else begin
        en_r <= en_r;
        ie_r <= ie_r;
      end
      if (ovf_s && ie_r) begin
        st_r <= 1'b1;
      end else if (wr_tcon_s) begin
        st_r <= bus.write_data[2];
      end else begin
        st_r <= st_r;
      end
    end
  end

  // Free-running systick, not writable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      systick_r <= 32'h0000_0000;
    end else begin
      systick_r <= systick_r + 32'h0000_0001;
    end
  end

  assign bus.read_data = read_data_s;
  assign bus.hit       = hit_s;
  assign bus.irq       = ie_r & st_r;
endmodule

// File: tb/tb_timer_periph.sv
// Directed self-checking bench for timer_periph; bus driven in the clock low phase.
module tb_timer_periph;
  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_SYSTICK = 32'h4000_000C;
  localparam logic [31:0] A_BAD     = 32'h4000_0010;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  timer_periph_if bus ();

  timer_periph #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.write_data = d;
    bus.mem_write  = 1'b1;
    @(negedge clk);
    bus.mem_write  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    bus.address  = a;
    bus.mem_read = 1'b1;
    #1;
    d = bus.read_data;
    h = bus.hit;
    bus.mem_read = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        h;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL reset_irq_held: got %b, expected 0", bus.irq); end
    reset = 1'b1;
    bus_read(A_TH, d, h);
    tests++; if ({h, d} !== {1'b1, 32'h0}) begin fails++; $display("FAIL reset_th: got hit=%b %h, expected hit=1 0", h, d); end
    bus_read(A_TL, d, h);
    tests++; if ({h, d} !== {1'b1, 32'h0}) begin fails++; $display("FAIL reset_tl: got hit=%b %h, expected hit=1 0", h, d); end
    bus_read(A_TCON, d, h);
    tests++; if ({h, d} !== {1'b1, 32'h0}) begin fails++; $display("FAIL reset_tcon: got hit=%b %h, expected hit=1 0", h, d); end
    bus_read(A_SYSTICK, d, h);
    tests++; if ({h, d} !== {1'b1, 32'h0}) begin fails++; $display("FAIL reset_systick: got hit=%b %h, expected hit=1 0", h, d); end
    bus_read(A_BAD, d, h);
    tests++; if ({h, d} !== {1'b0, 32'h0}) begin fails++; $display("FAIL decode_bad: got hit=%b %h, expected hit=0 0", h, d); end
    bus.address = A_TL;
    #1;
    tests++; if ({bus.hit, bus.read_data} !== {1'b1, 32'h0}) begin fails++; $display("FAIL no_read_zero: got hit=%b %h, expected hit=1 0", bus.hit, bus.read_data); end
    tests++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b, expected 0", bus.irq); end
  endtask

  task automatic test_basic_overflow();
    logic [31:0] d;
    logic        h;
    bus_write(A_TH, 32'hFFFF_FFF0);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'h0000_0003);
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'hFFFF_FFFE) begin fails++; $display("FAIL ovf_start: got %h, expected fffffffe", d); end
    @(negedge clk);
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL ovf_tl1: got %h, expected ffffffff", d); end
    tests++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL ovf_irq_early: got %b, expected 0", bus.irq); end
    @(negedge clk);
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'hFFFF_FFF0) begin fails++; $display("FAIL ovf_reload: got %h, expected fffffff0", d); end
    bus_read(A_TCON, d, h);
    tests++; if (d !== 32'h0000_0007) begin fails++; $display("FAIL ovf_tcon: got %h, expected 7", d); end
    tests++; if (bus.irq !== 1'b1) begin fails++; $display("FAIL ovf_irq: got %b, expected 1", bus.irq); end
    repeat (15) @(negedge clk);
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL ovf_15: got %h, expected ffffffff", d); end
    // ISR clear lands on the overflow edge: set wins
    bus_write(A_TCON, 32'h0000_0002);
    bus_read(A_TCON, d, h);
    tests++; if (d !== 32'h0000_0006) begin fails++; $display("FAIL isr_race_tcon: got %h, expected 6", d); end
    tests++; if (bus.irq !== 1'b1) begin fails++; $display("FAIL isr_race_irq: got %b, expected 1", bus.irq); end
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'hFFFF_FFF0) begin fails++; $display("FAIL isr_race_tl: got %h, expected fffffff0", d); end
    bus_write(A_TCON, 32'h0000_0002);
    bus_read(A_TCON, d, h);
    tests++; if (d !== 32'h0000_0002) begin fails++; $display("FAIL isr_clear_tcon: got %h, expected 2", d); end
    tests++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL isr_clear_irq: got %b, expected 0", bus.irq); end
    @(negedge clk);
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'hFFFF_FFF0) begin fails++; $display("FAIL en0_hold: got %h, expected fffffff0", d); end
  endtask

  task automatic test_ie_off();
    logic [31:0] d;
    logic        h;
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'h0000_0001);
    @(negedge clk);
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'hFFFF_FFF0) begin fails++; $display("FAIL ie0_reload: got %h, expected fffffff0", d); end
    bus_read(A_TCON, d, h);
    tests++; if (d !== 32'h0000_0001) begin fails++; $display("FAIL ie0_tcon: got %h, expected 1", d); end
    tests++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL ie0_irq: got %b, expected 0", bus.irq); end
  endtask

  task automatic test_write_vs_overflow();
    logic [31:0] d;
    logic        h;
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TL, 32'h0000_0005);
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'h0000_0005) begin fails++; $display("FAIL tl_wr_wins: got %h, expected 5", d); end
    @(negedge clk);
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'h0000_0006) begin fails++; $display("FAIL tl_wr_next: got %h, expected 6", d); end
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TH, 32'h0000_1234);
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'hFFFF_FFF0) begin fails++; $display("FAIL th_wr_old_reload: got %h, expected fffffff0", d); end
    bus_read(A_TH, d, h);
    tests++; if (d !== 32'h0000_1234) begin fails++; $display("FAIL th_wr_new: got %h, expected 1234", d); end
  endtask

  task automatic test_read_write_same();
    logic [31:0] d;
    logic        h;
    bus.address    = A_TH;
    bus.write_data = 32'hABCD_0001;
    bus.mem_write  = 1'b1;
    bus.mem_read   = 1'b1;
    #1;
    tests++; if (bus.read_data !== 32'h0000_1234) begin fails++; $display("FAIL rw_old: got %h, expected 1234", bus.read_data); end
    @(negedge clk);
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus_read(A_TH, d, h);
    tests++; if (d !== 32'hABCD_0001) begin fails++; $display("FAIL rw_new: got %h, expected abcd0001", d); end
  endtask

  task automatic test_systick();
    logic [31:0] s0;
    logic [31:0] s1;
    logic        h;
    bus_read(A_SYSTICK, s0, h);
    bus_write(A_SYSTICK, 32'h0000_0000);
    repeat (2) @(negedge clk);
    bus_read(A_SYSTICK, s1, h);
    tests++; if (s1 !== s0 + 32'd3) begin fails++; $display("FAIL systick: got %h, expected %h", s1, s0 + 32'd3); end
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] d;
    logic        h;
    bus_write(A_TCON, 32'h0000_0003);
    bus_write(A_TL, 32'hFFFF_FFFF);
    @(negedge clk);
    tests++; if (bus.irq !== 1'b1) begin fails++; $display("FAIL rst_pre_irq: got %b, expected 1", bus.irq); end
    #2;
    reset = 1'b0;
    #1;
    tests++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL rst_async_irq: got %b, expected 0", bus.irq); end
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_async_tl: got %h, expected 0", d); end
    bus_read(A_TH, d, h);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_async_th: got %h, expected 0", d); end
    bus_read(A_TCON, d, h);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_async_tcon: got %h, expected 0", d); end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_no_count: got %h, expected 0", d); end
  endtask

`ifdef TIMER_PRESCALER_EN
  task automatic test_prescaler();
    logic [31:0] d;
    logic [31:0] s0;
    logic [31:0] s1;
    logic        h;
    bus_write(A_TL, 32'h0000_0000);
    bus_write(A_TCON, 32'h0000_0001);
    bus_read(A_SYSTICK, s0, h);
    repeat (4) @(negedge clk);
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'h0000_0001) begin fails++; $display("FAIL pre_4: got %h, expected 1", d); end
    repeat (4) @(negedge clk);
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'h0000_0002) begin fails++; $display("FAIL pre_8: got %h, expected 2", d); end
    bus_read(A_SYSTICK, s1, h);
    tests++; if (s1 !== s0 + 32'd8) begin fails++; $display("FAIL pre_systick: got %h, expected %h", s1, s0 + 32'd8); end
    bus_write(A_TCON, 32'h0000_0001);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    bus_read(A_TL, d, h);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL pre_rst_tl: got %h, expected 0", d); end
    @(negedge clk);
    reset = 1'b1;
  endtask
`endif

  initial begin
    tests          = 0;
    fails          = 0;
    reset          = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.address    = 32'h0;
    bus.write_data = 32'h0;
    test_reset();
    test_basic_overflow();
    test_ie_off();
    test_write_vs_overflow();
    test_read_write_same();
    test_systick();
    test_reset_mid_count();
`ifdef TIMER_PRESCALER_EN
    test_prescaler();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
